// File: rtl/y_accum_pkg.sv
// y_accum_pkg: shared width, state encoding and clog2 helper for y_accum.
package y_accum_pkg;
   localparam int DATA_W = 18;
   typedef enum logic {ACCUM, HOLD} state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/y_accum.sv
// y_accum: sums N product samples, presenting sum and mean through valid/ready.
// Optional Y_ACCUM_PEAK_EN adds out_peak, the largest sample of the block.
module y_accum
   import y_accum_pkg::*;
#(
   parameter int N = 8,
   localparam int LN = clog2(N),
   localparam int ACC_W = DATA_W + LN
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              clr,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [DATA_W-1:0] out_mean,
   output logic [LN:0]       out_cnt
`ifdef Y_ACCUM_PEAK_EN
   ,
   output logic [DATA_W-1:0] out_peak
`endif
);
   state_t state, state_d;
   logic [ACC_W-1:0] acc, sum_next;
   logic [LN:0] cnt;
   logic hs, last;
   assign in_ready  = state == ACCUM;
   assign out_valid = state == HOLD;
   assign out_cnt   = cnt;
   assign hs        = in_valid & in_ready;
   assign last      = cnt == (LN+1)'(N-1);
   assign sum_next  = acc + ACC_W'(in_data);
   always_comb begin
      state_d = clr ? ACCUM
              : (state == ACCUM) ? ((hs && last) ? HOLD : ACCUM)
              : (out_ready ? ACCUM : HOLD);
   end
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= ACCUM;
         acc      <= '0;
         cnt      <= '0;
         out_sum  <= '0;
         out_mean <= '0;
      end else begin
         state <= state_d;
         if (clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (hs) begin
            acc <= last ? '0 : sum_next;
            cnt <= last ? '0 : cnt + (LN+1)'(1);
            if (last) begin
               out_sum  <= sum_next;
               out_mean <= sum_next[ACC_W-1:LN];
            end
         end
      end
   end
`ifdef Y_ACCUM_PEAK_EN
   logic [DATA_W-1:0] pk, pk_next;
   assign pk_next = (in_data > pk) ? in_data : pk;
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pk       <= '0;
         out_peak <= '0;
      end else if (clr) begin
         pk <= '0;
      end else if (hs) begin
         pk <= last ? '0 : pk_next;
         if (last) out_peak <= pk_next;
      end
   end
`endif
endmodule

// File: tb/tb_y_accum.sv
// tb_y_accum: directed self-checking bench for y_accum at the default N=8.
module tb_y_accum;
   logic        sys_clk = 0;
   logic        sys_rst = 1;
   logic        clr = 0;
   logic        in_valid = 0;
   logic [17:0] in_data = 0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1;
   logic [20:0] out_sum;
   logic [17:0] out_mean;
   logic [3:0]  out_cnt;
`ifdef Y_ACCUM_PEAK_EN
   logic [17:0] out_peak;
`endif
   int tests = 0;
   int fails = 0;

   y_accum dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_mean(out_mean), .out_cnt(out_cnt)
`ifdef Y_ACCUM_PEAK_EN
      , .out_peak(out_peak)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input logic [17:0] d);
      in_valid = 1;
      in_data  = d;
      step();
      in_valid = 0;
   endtask

   task automatic test_reset();
      sys_rst = 1;
      step();
      step();
      sys_rst = 0;
      tests++;
      if ({out_valid, in_ready, out_sum, out_mean, out_cnt} !== {1'b0, 1'b1, 21'd0, 18'd0, 4'd0}) begin
         fails++;
         $display("FAIL reset: valid=%0b ready=%0b sum=%0d mean=%0d cnt=%0d, want 0 1 0 0 0",
                  out_valid, in_ready, out_sum, out_mean, out_cnt);
      end
   endtask

   task automatic test_basic();
      out_ready = 1;
      for (int i = 0; i < 7; i++) send(18'd1);
      tests++;
      if (out_valid !== 1'b0 || out_cnt !== 4'd7) begin
         fails++;
         $display("FAIL basic_pre: valid=%0b cnt=%0d, want 0 7", out_valid, out_cnt);
      end
      send(18'd1);
      tests++;
      if ({out_valid, in_ready, out_sum, out_mean, out_cnt} !== {1'b1, 1'b0, 21'd8, 18'd1, 4'd0}) begin
         fails++;
         $display("FAIL basic_result: valid=%0b ready=%0b sum=%0d mean=%0d cnt=%0d, want 1 0 8 1 0",
                  out_valid, in_ready, out_sum, out_mean, out_cnt);
      end
      step();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL basic_bubble: valid=%0b ready=%0b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_max();
      for (int i = 0; i < 8; i++) send(18'd260100);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 21'd2080800 || out_mean !== 18'd260100) begin
         fails++;
         $display("FAIL max: valid=%0b sum=%0d mean=%0d, want 1 2080800 260100",
                  out_valid, out_sum, out_mean);
      end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 0;
      for (int i = 0; i < 8; i++) send(18'(i));
      in_valid = 1;
      in_data  = 18'd9;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if ({out_valid, in_ready, out_sum, out_mean, out_cnt} !== {1'b1, 1'b0, 21'd28, 18'd3, 4'd0}) begin
            fails++;
            $display("FAIL hold_%0d: valid=%0b ready=%0b sum=%0d mean=%0d cnt=%0d, want 1 0 28 3 0",
                     i, out_valid, in_ready, out_sum, out_mean, out_cnt);
         end
         step();
      end
      out_ready = 1;
      step();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_cnt !== 4'd0) begin
         fails++;
         $display("FAIL hold_release: valid=%0b ready=%0b cnt=%0d, want 0 1 0", out_valid, in_ready, out_cnt);
      end
      step();
      in_valid = 0;
      tests++;
      if (out_cnt !== 4'd1) begin
         fails++;
         $display("FAIL hold_nine_taken: cnt=%0d, want 1", out_cnt);
      end
      for (int i = 0; i < 7; i++) send(18'd1);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 21'd16 || out_mean !== 18'd2) begin
         fails++;
         $display("FAIL hold_next_block: valid=%0b sum=%0d mean=%0d, want 1 16 2", out_valid, out_sum, out_mean);
      end
      step();
   endtask

   task automatic test_clr();
      for (int i = 0; i < 3; i++) send(18'd100);
      tests++;
      if (out_cnt !== 4'd3) begin
         fails++;
         $display("FAIL clr_pre: cnt=%0d, want 3", out_cnt);
      end
      clr = 1;
      send(18'd50);
      clr = 0;
      tests++;
      if (out_cnt !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL clr_after: cnt=%0d valid=%0b ready=%0b, want 0 0 1", out_cnt, out_valid, in_ready);
      end
      for (int i = 0; i < 8; i++) send(18'd2);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 21'd16 || out_mean !== 18'd2) begin
         fails++;
         $display("FAIL clr_result: valid=%0b sum=%0d mean=%0d, want 1 16 2", out_valid, out_sum, out_mean);
      end
      step();
   endtask

   task automatic test_rst_mid();
      for (int i = 0; i < 5; i++) send(18'd7);
      sys_rst = 1;
      step();
      tests++;
      if ({out_valid, out_sum, out_mean, out_cnt} !== {1'b0, 21'd0, 18'd0, 4'd0}) begin
         fails++;
         $display("FAIL rst_during: valid=%0b sum=%0d mean=%0d cnt=%0d, want 0 0 0 0",
                  out_valid, out_sum, out_mean, out_cnt);
      end
      sys_rst = 0;
      step();
      tests++;
      if ({out_valid, in_ready, out_sum, out_mean, out_cnt} !== {1'b0, 1'b1, 21'd0, 18'd0, 4'd0}) begin
         fails++;
         $display("FAIL rst_after: valid=%0b ready=%0b sum=%0d mean=%0d cnt=%0d, want 0 1 0 0 0",
                  out_valid, in_ready, out_sum, out_mean, out_cnt);
      end
      for (int i = 0; i < 7; i++) send(18'd10);
      tests++;
      if (out_valid !== 1'b0 || out_sum !== 21'd0) begin
         fails++;
         $display("FAIL rst_no_partial: valid=%0b sum=%0d, want 0 0", out_valid, out_sum);
      end
      send(18'd10);
      tests++;
      if (out_valid !== 1'b1 || out_sum !== 21'd80 || out_mean !== 18'd10) begin
         fails++;
         $display("FAIL rst_result: valid=%0b sum=%0d mean=%0d, want 1 80 10", out_valid, out_sum, out_mean);
      end
      step();
   endtask

`ifdef Y_ACCUM_PEAK_EN
   task automatic test_peak();
      logic [17:0] v [8];
      v = '{18'd3, 18'd900, 18'd7, 18'd1, 18'd0, 18'd899, 18'd2, 18'd5};
      for (int i = 0; i < 8; i++) send(v[i]);
      tests++;
      if (out_valid !== 1'b1 || out_peak !== 18'd900 || out_sum !== 21'd1817 || out_mean !== 18'd227) begin
         fails++;
         $display("FAIL peak: valid=%0b peak=%0d sum=%0d mean=%0d, want 1 900 1817 227",
                  out_valid, out_peak, out_sum, out_mean);
      end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_clr();
      test_rst_mid();
`ifdef Y_ACCUM_PEAK_EN
      test_peak();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/y_accum.md
Name: y_accum

Overview:
- Downstream stage for the (A+B)*(C+D) arithmetic datapath.
- Consumes the 18-bit product stream through a valid/ready handshake and sums N consecutive products.
- Presents the sum and the mean (sum >> log2 N) through a valid/ready output that holds until it is accepted.
- Converts the combinational product into a registered, flow-controlled result stream for later stages.

Parameters:
- DATA_W, 18, width of input product; matches the multiplier output.
- N, 8, samples per block; must be a power of 2, 2..256.
- ACC_W, DATA_W+log2(N), width of sum output; derived, not overridden.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of the partial block and of any pending result.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DATA_W  product sample.
- in_ready  output  1  block accepts a sample this cycle.
- out_valid  output  1  out_sum/out_mean are valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  sum of N samples.
- out_mean  output  DATA_W  out_sum >> log2(N), truncating.
- out_cnt  output  log2(N)+1  samples accumulated in the current block.

Behaviour:
- Clock and reset:
  - One clock, sys_clk.
  - sys_rst is synchronous, active-high.
  - Priority: sys_rst > clr > handshakes.
- Reset values: state=ACCUM, acc=0, cnt=0, out_valid=0, out_sum=0, out_mean=0. in_ready=1 in the first cycle after reset.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM transitions:
  - An input handshake is in_valid & in_ready. On a handshake with cnt<N-1: acc<=acc+in_data, cnt<=cnt+1.
  - On a handshake with cnt==N-1: out_sum<=acc+in_data, out_mean<=(acc+in_data)>>log2(N), acc<=0, cnt<=0, go to HOLD.
  - No handshake: hold all state.
- HOLD transitions:
  - out_sum and out_mean stay stable while out_valid & !out_ready.
  - On out_ready: out_valid<=0, go to ACCUM. The next sample can be accepted in the following cycle (one bubble per block).
  - in_valid is ignored in HOLD because in_ready=0. The upstream must hold its data.
- Latency: out_valid rises 1 cycle after the Nth input handshake.
- Width: the sum is never truncated. Worst case is 8 x 260100 = 2080800 < 2^21, so there is no overflow at the defaults.
- clr:
  - Clears acc and cnt, clears out_valid, forces ACCUM.
  - A sample presented in the same cycle as clr is discarded.
- Reset mid-block or mid-HOLD discards everything. No partial result is ever emitted.
- out_cnt reflects cnt: 0..N-1 in ACCUM, 0 in HOLD.
- in_ready is a function of state only (registered state, no combinational path from out_ready).

Optional Feature:
- Macro Y_ACCUM_PEAK_EN.
- When defined:
  - Adds output out_peak [DATA_W-1:0], the maximum sample in the block.
  - It is captured together with out_sum and held under the same rules.
  - The running peak resets with acc, on clr and on sys_rst.
- When undefined: the port and logic are absent. All other behaviour is identical.

Decomposition:
- Package y_accum_pkg holds:
  - localparam DATA_W=18;
  - the state enum {ACCUM, HOLD};
  - the function clog2 used for ACC_W and the out_cnt width.
- No sub-module is needed. The datapath (adder plus counter) and the 2-state FSM live in one module.

Test Plan:
1. Reset, then 8 samples of 1 back-to-back with out_ready=1 -> out_valid high 1 cycle after the 8th; out_sum=8, out_mean=1; in_ready low exactly 1 cycle.
2. 8 samples of 260100 (A=B=C=D=255) -> out_sum=2080800, out_mean=260100, no wrap.
3. Samples 0..7, out_ready held low 5 cycles, in_valid held high with data 9 -> out_sum=28 and out_mean=3 stable, in_ready=0 throughout, the 9 is not consumed until out_ready; the next block starts with 9.
4. 3 samples of 100, then clr with in_valid=1 and data 50, then 8 samples of 2 -> out_sum=16; 100s and 50 discarded; out_cnt=0 after clr.
5. 5 samples, sys_rst for 1 cycle, then 8 samples of 10 -> out_sum=80; all outputs 0 during and after reset until the result.
6. With Y_ACCUM_PEAK_EN defined: samples 3,900,7,1,0,899,2,5 -> out_peak=900, out_sum=1817.
